// File: rtl/core_seq_pkg.sv
// Shared types and widths for the core sequencer: state encoding and wait-counter width.
package core_seq_pkg;

    localparam int STATE_W = 3;
    // Wide enough for ALU_TIMEOUT up to 1023 and FETCH_LAT-1 up to 14.
    localparam int WAIT_W = 10;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

endpackage

// File: rtl/seq_wait_cnt.sv
// Loadable down-counter with a terminal flag.
// Shared between the fetch-latency wait and the ALU timeout wait.
module seq_wait_cnt
    import core_seq_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Define CORE_SEQ_TIMEOUT_EN to trap when a multi-cycle ALU op never reports alu_done.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int FETCH_LAT   = 1,
    parameter int ALU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               is_mem,
    input  logic               is_multi,
    input  logic               alu_done,
    input  logic               mem_ready,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               alu_start,
    output logic               mem_req,
    output logic               wb_en,
    output logic               pc_we,
    output logic               busy,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   retired,
    output logic               err
);

    localparam logic [WAIT_W-1:0] FETCH_LOAD   = WAIT_W'(FETCH_LAT - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_LOAD = WAIT_W'(ALU_TIMEOUT);

    state_t state_q;
    state_t state_d;
    logic   exec_first;
    logic   wait_done;
    logic   wait_load;
    state_t exec_exit;

    // The counter is reloaded on every state change; only FETCH and EXEC consult it.
    assign wait_load = (state_d != state_q);

    seq_wait_cnt #(.W(WAIT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val ((state_d == FETCH) ? FETCH_LOAD : TIMEOUT_LOAD),
        .en       (1'b1),
        .done     (wait_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            exec_first <= 1'b0;
            retired    <= '0;
        end else begin
            state_q    <= state_d;
            exec_first <= (state_d == EXEC) && (state_q != EXEC);
            if (state_q == WB) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign exec_exit = is_mem ? MEM : WB;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (run) state_d = FETCH;
            FETCH:  if (wait_done) state_d = DECODE;
            DECODE: state_d = EXEC;
            EXEC: begin
                // alu_done coincident with alu_start belongs to no op of ours.
                if (!is_multi) begin
                    state_d = exec_exit;
                end else if (!exec_first && alu_done) begin
                    state_d = exec_exit;
`ifdef CORE_SEQ_TIMEOUT_EN
                end else if (!exec_first && wait_done) begin
                    state_d = TRAP;
`endif
                end
            end
            MEM:    if (mem_ready) state_d = WB;
            WB:     state_d = run ? FETCH : IDLE;
            TRAP:   state_d = TRAP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_en  = (state_q == FETCH);
        decode_en = (state_q == DECODE);
        alu_start = (state_q == EXEC) && exec_first;
        mem_req   = (state_q == MEM);
        wb_en     = (state_q == WB);
        pc_we     = (state_q == WB);
        busy      = (state_q != IDLE) && (state_q != TRAP);
`ifdef CORE_SEQ_TIMEOUT_EN
        err       = (state_q == TRAP);
`else
        err       = 1'b0;
`endif
    end

    assign state = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: random instruction mix vs per-instruction phase-length model.
module tb_core_sequencer;

    localparam int FETCH_LAT   = 3;
    localparam int ALU_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int EW          = 36;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_TRAP = 3'd6;

    logic clk, rst, run, is_mem, is_multi, alu_done, mem_ready;
    logic fetch_en, decode_en, alu_start, mem_req, wb_en, pc_we, busy, err;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    core_sequencer #(.FETCH_LAT(FETCH_LAT), .ALU_TIMEOUT(ALU_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run), .is_mem(is_mem), .is_multi(is_multi),
        .alu_done(alu_done), .mem_ready(mem_ready), .fetch_en(fetch_en),
        .decode_en(decode_en), .alu_start(alu_start), .mem_req(mem_req),
        .wb_en(wb_en), .pc_we(pc_we), .busy(busy), .state(state),
        .retired(retired), .err(err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];
    int model_retired = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Returns at the first negedge (current one included) where the selected strobe is high.
    task automatic wait_for(input int sel);
        for (int i = 0; i < 300; i++) begin
            logic hit;
            case (sel)
                0: hit = fetch_en;
                1: hit = alu_start;
                2: hit = mem_req;
                default: hit = wb_en;
            endcase
            if (hit) return;
            @(negedge clk);
        end
        n_checks++;
        $display("FAIL wait_strobe_%0d: strobe not seen within 300 cycles, got 0, expected 1", sel);
    endtask

    // driver: one instruction, with the model's expectation pushed at fetch
    task automatic do_instr(input bit multi, input bit mem, input int d, input int r,
                            input bit spurious, input bit drop_run);
        int ex_cyc, mem_cyc, total;
        wait_for(0);
        is_multi = multi;
        is_mem   = mem;
        ex_cyc  = multi ? d + 1 : 1;
        mem_cyc = mem ? r + 1 : 0;
        total   = FETCH_LAT + 1 + ex_cyc + mem_cyc + 1;
        exp_q.push_back({8'(FETCH_LAT), 8'(ex_cyc), 8'(mem_cyc), 8'(total), 4'(model_retired)});
        model_retired = (model_retired + 1) % (1 << CNT_W);
        wait_for(1);
        if (multi) begin
            if (spurious) alu_done = 1'b1;
            @(negedge clk);
            alu_done = 1'b0;
            repeat (d - 1) @(negedge clk);
            alu_done = 1'b1;
            @(negedge clk);
            alu_done = 1'b0;
        end
        if (mem) begin
            wait_for(2);
            repeat (r) @(negedge clk);
            mem_ready = 1'b1;
            if (drop_run) run = 1'b0;
            @(negedge clk);
            mem_ready = 1'b0;
        end
        wait_for(3);
    endtask

    // monitor / scoreboard
    int c_fetch, c_dec, c_start, c_exec, c_mem, c_busy;
    bit pend_ret;
    int pend_val;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        if (rst) begin
            c_fetch = 0; c_dec = 0; c_start = 0; c_exec = 0; c_mem = 0; c_busy = 0;
            pend_ret = 0;
        end else begin
            if (pend_ret) begin
                check("retired_after_wb", retired, pend_val);
                pend_ret = 0;
            end
            c_fetch += int'(fetch_en);
            c_dec   += int'(decode_en);
            c_start += int'(alu_start);
            c_exec  += int'(state == ST_EXEC);
            c_mem   += int'(mem_req);
            c_busy  += int'(busy);
            if (wb_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wb", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("fetch_cycles",  c_fetch, e[35:28]);
                    check("decode_cycles", c_dec, 1);
                    check("alu_starts",    c_start, 1);
                    check("exec_cycles",   c_exec, e[27:20]);
                    check("mem_cycles",    c_mem, e[19:12]);
                    check("instr_cycles",  c_busy, e[11:4]);
                    check("pc_we_with_wb", pc_we, 1);
                    check("retired_at_wb", retired, e[3:0]);
                    check("err_clear",     err, 0);
                    pend_ret = 1;
                    pend_val = (int'(e[3:0]) + 1) % (1 << CNT_W);
                end
                c_fetch = 0; c_dec = 0; c_start = 0; c_exec = 0; c_mem = 0; c_busy = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    // stimulus
    initial begin
        bit m, mm;
        int d, r;
        rst = 1'b1; run = 1'b0; is_mem = 1'b0; is_multi = 1'b0;
        alu_done = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state",   state, ST_IDLE);
        check("reset_busy",    busy, 0);
        check("reset_retired", retired, 0);
        check("reset_err",     err, 0);
        check("reset_strobes", {fetch_en, decode_en, alu_start, mem_req, wb_en, pc_we}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_hold_state", state, ST_IDLE);
        check("idle_hold_fetch", fetch_en, 0);
        run = 1'b1;

        // directed openers, then random mix (20 total so retired wraps past 15)
        do_instr(0, 0, 1, 0, 0, 0);
        do_instr(0, 1, 1, 2, 0, 0);
        do_instr(1, 0, 5, 0, 1, 0);
        for (int i = 0; i < 17; i++) begin
            m  = 1'($urandom_range(0, 1));
            mm = 1'($urandom_range(0, 1));
            d  = $urandom_range(1, 6);
            r  = $urandom_range(0, 3);
            do_instr(m, mm, d, r, 1'($urandom_range(0, 1)), 0);
        end

        // run dropped during MEM: instruction completes then parks in IDLE
        do_instr(1, 1, 3, 1, 0, 1);
        @(negedge clk);
        check("drop_run_idle",    state, ST_IDLE);
        check("drop_run_busy",    busy, 0);
        check("drop_run_retired", retired, model_retired);

        // rerun and reset mid-FETCH
        run = 1'b1;
        wait_for(0);
        rst = 1'b1;
        exp_q.delete();
        model_retired = 0;
        @(negedge clk);
        check("midfetch_rst_state",   state, ST_IDLE);
        check("midfetch_rst_retired", retired, 0);
        check("midfetch_rst_busy",    busy, 0);
        check("midfetch_rst_strobes", {fetch_en, decode_en, alu_start, mem_req, wb_en, pc_we}, 0);
        run = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        run = 1'b1;
        do_instr(0, 1, 1, 0, 0, 1);
        @(negedge clk);
        check("post_rst_idle", state, ST_IDLE);

`ifdef CORE_SEQ_TIMEOUT_EN
        run = 1'b1;
        is_multi = 1'b1;
        is_mem = 1'b0;
        wait_for(1);
        run = 1'b0;
        repeat (ALU_TIMEOUT) @(negedge clk);
        check("timeout_last_wait", state, ST_EXEC);
        @(negedge clk);
        check("trap_state", state, ST_TRAP);
        check("trap_err",   err, 1);
        check("trap_busy",  busy, 0);
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("trap_sticky", state, ST_TRAP);
        check("trap_strobes", {fetch_en, decode_en, alu_start, mem_req, wb_en, pc_we}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        check("trap_rst_state", state, ST_IDLE);
        check("trap_rst_err",   err, 0);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter FETCH_LAT, default 1, meaning instruction-ROM read latency in cycles (legal 1..15).
REQ-002 SHALL have parameter ALU_TIMEOUT, default 64, meaning max cycles to wait for alu_done (legal 2..1023).
REQ-003 SHALL have parameter CNT_W, default 32, meaning retired-instruction counter width.
REQ-004 SHALL have one clock; reset is synchronous and active-high: clk  in  1  core clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 run  in  1  level; 1 = keep issuing instructions.
REQ-007 is_mem  in  1  decoded instruction is load/store, valid from DECODE until WB.
REQ-008 is_multi  in  1  decoded ALU op is multi-cycle, valid from DECODE until WB.
REQ-009 alu_done  in  1  multi-cycle ALU result ready (one-cycle pulse).
REQ-010 mem_ready  in  1  RAM accepts/completes access this cycle.
REQ-011 fetch_en  out  1  ROM read enable.
REQ-012 decode_en  out  1  decoder latch strobe.
REQ-013 alu_start  out  1  ALU start pulse.
REQ-014 mem_req  out  1  RAM access request.
REQ-015 wb_en  out  1  register-file write strobe.
REQ-016 pc_we  out  1  PC update strobe.
REQ-017 busy  out  1  high in every state except IDLE and TRAP.
REQ-018 state  out  3  current state encoding.
REQ-019 retired  out  CNT_W  retired-instruction count.
REQ-020 err  out  1  sticky ALU-timeout flag.

Function
REQ-021 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs registered or decoded from state only.
REQ-022 IDLE: all strobes 0; run=1 -> FETCH next cycle.
REQ-023 FETCH: fetch_en=1 for exactly FETCH_LAT cycles, then -> DECODE.
REQ-024 DECODE: decode_en=1 for one cycle -> EXEC.
REQ-025 EXEC: alu_start=1 on the first EXEC cycle only; is_multi=0 -> leave after that one cycle.
REQ-026 EXEC with is_multi=1: alu_done sampled from the cycle after alu_start; alu_done on the first EXEC cycle is ignored.
REQ-027 EXEC exit target: MEM if is_mem=1, else WB.
REQ-028 MEM: mem_req=1 held until mem_ready=1 in the same cycle; mem_ready on the first MEM cycle exits immediately -> WB.
REQ-029 WB: wb_en=1 and pc_we=1 for one cycle; retired increments by 1, wrapping from all-ones to 0.
REQ-030 WB exit: run=1 -> FETCH, run=0 -> IDLE; run deassertion mid-instruction SHALL NOT abort it.
REQ-031 Latency with FETCH_LAT=1, single-cycle ALU, non-memory instruction: 4 cycles/instruction (FETCH, DECODE, EXEC, WB).
REQ-032 TRAP: all strobes 0, err=1, busy=0; exit only by reset.

Reset
REQ-033 rst=1 at a clock edge SHALL force state=IDLE, all strobes 0, busy=0, err=0, retired=0, counters 0, from any state including mid-FETCH/EXEC/MEM.
REQ-034 rst SHALL take priority over every simultaneous input event.

Configuration
REQ-035 Macro CORE_SEQ_TIMEOUT_EN defined: a wait counter in EXEC (is_multi=1) reaching ALU_TIMEOUT cycles without alu_done -> TRAP, err=1.
REQ-036 Macro undefined: EXEC waits indefinitely for alu_done, TRAP unreachable, err tied 0; ALU_TIMEOUT unused.
REQ-037 alu_done in the same cycle the counter reaches ALU_TIMEOUT SHALL win (no trap).

Structure
REQ-038 Package core_seq_pkg SHALL hold the state typedef (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6) and the 3-bit state width constant.
REQ-039 One sub-module seq_wait_cnt (load/count/terminal flag) SHALL serve both the FETCH_LAT counter and the timeout counter.

Verification
REQ-040 FETCH_LAT=1, run=1, is_multi=0, is_mem=0 for 3 instructions -> wb_en at cycles 4, 8, 12 after reset release; retired=3.
REQ-041 FETCH_LAT=3, is_mem=1, mem_ready high 2 cycles after MEM entry -> fetch_en 3 cycles, mem_req 3 cycles, one wb_en.
REQ-042 is_multi=1, alu_done 5 cycles after alu_start -> exactly one alu_start, EXEC lasts 6 cycles, no err.
REQ-043 CORE_SEQ_TIMEOUT_EN, ALU_TIMEOUT=8, alu_done never -> state=TRAP, err=1 after 8 wait cycles; stays until rst.
REQ-044 CNT_W=4, 17 instructions -> retired wraps 15 -> 0 -> 1.
REQ-045 run dropped during MEM, then rst asserted in following FETCH of a rerun -> current instruction completes to IDLE; rst yields IDLE, retired=0.
